// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg -- shared encodings for the multi-cycle MIPS sequencer.
// Holds the instruction opcode/func encodings, the ALU-operation and
// PC-source encodings, the sequencer state enum, the decoded control-word
// struct and a saturating-increment helper.
package mips_ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU operation encodings
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  // PC source encodings
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

  // branch=1 marks beq: the final PC source is resolved from the zero flag
  // captured in EXEC, so pc_src is only meaningful when branch=0.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic       branch;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_NOP = '0;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/mips_decoder.sv
// mips_decoder -- purely combinational instruction decode.
// Ports:
//   opcode  in  6  primary opcode
//   func    in  6  R-type function field
//   cw      out    decoded control word (all zero when illegal)
//   illegal out 1  encoding not supported
module mips_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output ctrl_word_t cw,
  output logic       illegal
);

  always_comb begin
    cw      = CTRL_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        // Common R-type ALU shape; jr overrides it below.
        cw.reg_dst    = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
        case (func)
          FN_ADD: cw.alu_op = ALU_ADD;
          FN_SUB: cw.alu_op = ALU_SUB;
          FN_AND: cw.alu_op = ALU_AND;
          FN_OR:  cw.alu_op = ALU_OR;
          FN_SLT: cw.alu_op = ALU_SLT;
          FN_JR: begin
            cw        = CTRL_NOP;
            cw.pc_src = PC_REG;
          end
          default: begin
            cw      = CTRL_NOP;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        cw.alu_src    = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.reg_write  = 1'b1;
      end
      OP_LW: begin
        cw.alu_src   = 1'b1;
        cw.mem_read  = 1'b1;
        cw.reg_write = 1'b1;
      end
      OP_SW: begin
        cw.alu_src   = 1'b1;
        cw.mem_write = 1'b1;
      end
      OP_BEQ: begin
        cw.alu_op = ALU_SUB;
        cw.branch = 1'b1;
      end
      OP_J: cw.pc_src = PC_JUMP;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_seq_ctrl.sv
// mips_seq_ctrl -- multi-cycle sequencer for a small MIPS datapath.
// Ports:
//   clk, reset (async, active-low)
//   start, step_mode, opcode, func, zero, done   -- control/datapath inputs
//   regWrite, memRead, memWrite, memToReg, aluSrc, regDst, pcSrc, aluOp
//                                                 -- registered datapath controls
//   dp_step, busy, halted, illegal, retired       -- status
// Sequence: IDLE -> FETCH -> EXEC -> [MEM] -> WB -> FETCH/IDLE/HALT.
module mips_seq_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter logic [15:0] MAX_RETIRE = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        step_mode,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        done,
  output logic        regWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic        memToReg,
  output logic        aluSrc,
  output logic        regDst,
  output logic [1:0]  pcSrc,
  output logic [2:0]  aluOp,
  output logic        dp_step,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired
);

  state_e     state_reg, state_next;
  ctrl_word_t cw_reg;
  ctrl_word_t dec_cw;
  logic       dec_illegal;
  logic       zero_reg;
  logic       dp_step_reg, reg_write_reg, mem_write_reg, illegal_reg;
  logic [1:0] pc_src_reg, pc_src_next;
  logic [15:0] retired_reg;
  logic       commit, zero_eff, limit_hit;

  mips_decoder u_decoder (
    .opcode  (opcode),
    .func    (func),
    .cw      (dec_cw),
    .illegal (dec_illegal)
  );

  // Widened compare so retired+1 cannot wrap at 16'hFFFF.
  assign limit_hit = ({1'b0, retired_reg} + 17'd1) >= {1'b0, MAX_RETIRE};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_FETCH;
      ST_FETCH: state_next = dec_illegal ? ST_HALT : ST_EXEC;
      ST_EXEC:  state_next = (cw_reg.mem_read || cw_reg.mem_write) ? ST_MEM : ST_WB;
      ST_MEM:   state_next = ST_WB;
      ST_WB: begin
        if (done || limit_hit)  state_next = ST_HALT;
        else if (step_mode)     state_next = ST_IDLE;
        else                    state_next = ST_FETCH;
      end
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output flops are loaded from the next state so they line up with WB.
  assign commit = (state_next == ST_WB);

  // beq leaves EXEC straight into WB, so the zero flag being captured on
  // that same edge must be taken from the input rather than zero_reg.
  assign zero_eff = (state_reg == ST_EXEC) ? zero : zero_reg;

  always_comb begin
    pc_src_next = PC_SEQ;
    if (commit) begin
      if (cw_reg.branch) pc_src_next = zero_eff ? PC_BRANCH : PC_SEQ;
      else               pc_src_next = cw_reg.pc_src;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cw_reg        <= CTRL_NOP;
      zero_reg      <= 1'b0;
      dp_step_reg   <= 1'b0;
      reg_write_reg <= 1'b0;
      mem_write_reg <= 1'b0;
      pc_src_reg    <= PC_SEQ;
      illegal_reg   <= 1'b0;
      retired_reg   <= 16'd0;
    end else begin
      state_reg     <= state_next;
      dp_step_reg   <= commit;
      reg_write_reg <= commit && cw_reg.reg_write;
      mem_write_reg <= commit && cw_reg.mem_write;
      pc_src_reg    <= pc_src_next;

      // The control word doubles as the EXEC..WB output register; it is
      // zero whenever no instruction is in flight.
      if (state_reg == ST_FETCH)
        cw_reg <= dec_illegal ? CTRL_NOP : dec_cw;
      else if (state_reg == ST_WB)
        cw_reg <= CTRL_NOP;

      if (state_reg == ST_EXEC) zero_reg <= zero;
      if (state_reg == ST_FETCH && dec_illegal) illegal_reg <= 1'b1;
      if (state_reg == ST_WB) retired_reg <= sat_inc16(retired_reg);
    end
  end

  assign regWrite = reg_write_reg;
  assign memWrite = mem_write_reg;
  assign memRead  = cw_reg.mem_read;
  assign memToReg = cw_reg.mem_to_reg;
  assign aluSrc   = cw_reg.alu_src;
  assign regDst   = cw_reg.reg_dst;
  assign aluOp    = cw_reg.alu_op;
  assign pcSrc    = pc_src_reg;
  assign dp_step  = dp_step_reg;
  assign busy     = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
  assign halted   = (state_reg == ST_HALT);
  assign illegal  = illegal_reg;
  assign retired  = retired_reg;

endmodule

// File: doc/mips_seq_ctrl.md
MIPS_SEQ_CTRL -- requirements
Module: mips_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETIRE, default 16'd1000: retired-instruction limit that forces HALT.
REQ-002 SHALL have ports in this order:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle pulse; begins or resumes execution.
- step_mode  in  1  1 = stop in IDLE after each commit.
- opcode  in  6  from the datapath.
- func  in  6  from the datapath.
- zero  in  1  ALU zero flag.
- done  in  1  program-complete flag.
REQ-003 SHALL drive these datapath control outputs, all registered:
- regWrite  out  1
- memRead  out  1
- memWrite  out  1
- memToReg  out  1  0 = data memory, 1 = ALU.
- aluSrc  out  1  0 = register, 1 = sign-extended immediate.
- regDst  out  1  0 = rt, 1 = rd.
- pcSrc  out  2  00 = pc+4, 01 = branch, 10 = register, 11 = jump.
- aluOp  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-004 SHALL drive these status outputs:
- dp_step  out  1  one-cycle datapath commit strobe (PC/register/memory advance enable).
- busy  out  1  high outside IDLE and HALT.
- halted  out  1  high in HALT.
- illegal  out  1  sticky; set on an undecodable instruction.
- retired  out  16  count of committed instructions.

Function
REQ-005 SHALL implement states IDLE, FETCH, EXEC, MEM, WB, HALT.
REQ-006 IDLE: start=1 SHALL go to FETCH next cycle; otherwise stay in IDLE.
REQ-007 FETCH SHALL decode opcode/func into a registered control word; an illegal encoding SHALL go to HALT with illegal=1 and no commit; otherwise go to EXEC.
REQ-008 EXEC SHALL register zero into zero_q; lw/sw SHALL go to MEM; all other instructions SHALL go to WB.
REQ-009 MEM SHALL go to WB.
REQ-010 WB SHALL pulse dp_step for exactly one cycle and increment retired, saturating at 16'hFFFF.
REQ-011 From WB, the next state SHALL be:
- HALT if done=1 or retired+1 ≥ MAX_RETIRE.
- else IDLE if step_mode=1.
- else FETCH.
REQ-012 regWrite and memWrite SHALL be high only in WB, coincident with dp_step.
REQ-013 memRead SHALL be high in EXEC, MEM and WB for lw.
REQ-014 aluSrc, regDst, memToReg and aluOp SHALL be held stable from EXEC through WB.
REQ-015 Decode SHALL be:
- R-type (000000): func 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, with regDst=1, memToReg=1, regWrite.
- jr (R-type, func 001000): pcSrc=10, no regWrite.
- addi (001000): aluSrc=1, memToReg=1, regWrite.
- lw (100011): aluSrc=1, memToReg=0, regWrite.
- sw (101011): aluSrc=1, memWrite.
- beq (000100): aluOp=sub; pcSrc=01 if zero_q, else 00.
- j (000010): pcSrc=11.
- Any other opcode or R-type func SHALL be illegal.
REQ-016 Outside WB, pcSrc SHALL be 00.
REQ-017 Latency SHALL be 3 cycles FETCH→commit for non-memory instructions and 4 cycles for lw/sw.
REQ-018 start SHALL be ignored while busy=1 or in HALT; HALT SHALL be exited only by reset.

Reset
REQ-019 reset=0 SHALL asynchronously force IDLE, clear all outputs to 0 (pcSrc=00, aluOp=000, retired=0, illegal=0) and clear zero_q.
REQ-020 Reset asserted mid-instruction SHALL abort it with no dp_step or write enable generated.

Structure
REQ-021 Package mips_ctrl_pkg SHALL hold the opcode, func, aluOp and pcSrc encodings, the state enum and the control-word struct.
REQ-022 Combinational decode SHALL live in sub-module mips_decoder (opcode, func → control word, illegal flag); the FSM, counter and output registers SHALL live in mips_seq_ctrl.

Verification
REQ-023 Reset, then start with opcode=000000, func=100000 → dp_step high 3 cycles after FETCH entry, regWrite=1, regDst=1, aluOp=000, retired=1.
REQ-024 lw (100011) → memRead high for EXEC/MEM/WB, memToReg=0, dp_step on the 4th cycle; sw (101011) → memWrite=1 only in WB, regWrite=0.
REQ-025 beq with zero=1 in EXEC → pcSrc=01 in WB; with zero=0 → pcSrc=00.
REQ-026 opcode=111111 → HALT, illegal=1, no dp_step; a subsequent start is ignored.
REQ-027 done=1 at WB → HALT after the commit. MAX_RETIRE=3 free-run → halted after exactly 3 dp_step pulses. step_mode=1 → IDLE after each commit.
REQ-028 reset=0 during MEM of lw → immediate IDLE, all outputs 0, retired unchanged from 0 after re-reset.
